spi_xfer_ctrl: RTL

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: byte-stream SPI master with per-frame latched mode,
// chip-select framing, inter-byte hold in NEXT and a minimum cs-high gap.
module spi_xfer_ctrl #(
  parameter int unsigned system_clk = 50_000000,
  parameter int unsigned spi_rate   = 5_000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic       miso,
  output logic       cs,
  output logic       sck,
  output logic       mosi
);

  localparam int unsigned RATIO = system_clk / spi_rate;
  localparam int unsigned N     = (RATIO < 4) ? 4 : RATIO;
  localparam int unsigned H     = N / 2;
  localparam int unsigned CW    = $clog2(N);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          cpol_q, cpol_d;
  logic          cpha_q, cpha_d;
  logic          last_q, last_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;

  logic       tx_ready_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d;
  logic       busy_d;
  logic       cs_d;
  logic       sck_d;
  logic       mosi_d;
  logic       accept;

  // Next-state, counters, latched frame context and next output values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    last_d     = last_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    mosi_d     = mosi;
    sck_d      = cpol_q;
    accept     = tx_valid && tx_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LEAD;
          cnt_d   = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          tx_d    = tx_data;
          last_d  = tx_last;
          mosi_d  = tx_data[7];
        end
      end
      S_LEAD: begin
        if (cnt_q == CW'(H - 1)) begin
          state_d = S_XFER;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == CW'(N - 1)) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            state_d    = last_q ? S_TRAIL : S_NEXT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        if (accept) begin
          state_d = S_XFER;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = tx_data;
          last_d  = tx_last;
        end
      end
      S_TRAIL: begin
        if (cnt_q == CW'(H - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // mosi moves only at bit start; miso captured as sck enters its second half
    if (state_d == S_XFER && cnt_d == '0) begin
      mosi_d = tx_d[3'd7 - bit_d];
    end
    if (state_d == S_XFER && cnt_d == CW'(H)) begin
      rx_sh_d = {rx_sh_q[6:0], miso};
    end

    case (state_d)
      S_IDLE:  sck_d = cpol;
      S_XFER:  sck_d = (cnt_d < CW'(H)) ? (cpol_d ^ cpha_d) : ~(cpol_d ^ cpha_d);
      default: sck_d = cpol_d;
    endcase

    cs_d       = (state_d == S_IDLE) || (state_d == S_GAP);
    tx_ready_d = (state_d == S_IDLE) || (state_d == S_NEXT);
    busy_d     = (state_d != S_IDLE);
  end

  // State, context and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      last_q   <= 1'b0;
      tx_q     <= '0;
      rx_sh_q  <= '0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      cs       <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      last_q   <= last_d;
      tx_q     <= tx_d;
      rx_sh_q  <= rx_sh_d;
      tx_ready <= tx_ready_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
      cs       <= cs_d;
      sck      <= sck_d;
      mosi     <= mosi_d;
    end
  end

endmodule
